load_id_buffer: RTL
===================

LOAD_ID_BUFFER -- requirements
Module: load_id_buffer

Interface
REQ-001 The block SHALL have parameter NR_ENTRIES, default 8, meaning the number of outstanding load slots (power of two, 2..16).
REQ-002 The block SHALL have parameter ID_WIDTH, default 3, meaning the dcache request/response ID width, equal to log2(NR_ENTRIES).
REQ-003 The block SHALL have parameter TRANS_ID_WIDTH, default 3, meaning the scoreboard transaction ID width.
REQ-004 The block SHALL have the port clk_i  in  1  clock; all logic is on the rising edge.
REQ-005 The block SHALL have the port rst_i  in  1  reset, synchronous and active-high.
REQ-006 The block SHALL have the allocation ports: alloc_valid_i in 1 load issued; alloc_ready_o out 1 free slot exists; alloc_trans_id_i in TRANS_ID_WIDTH; alloc_offset_i in 3 byte offset in dword; alloc_size_i in 2 (0=B,1=H,2=W,3=D); alloc_signed_i in 1 sign-extend; alloc_id_o out ID_WIDTH slot granted.
REQ-007 The block SHALL have the response ports: rsp_valid_i in 1; rsp_id_i in ID_WIDTH; rsp_data_i in 64 raw dword.
REQ-008 The block SHALL have the control port flush_i  in  1  kill all in-flight loads.
REQ-009 The block SHALL have the writeback ports: wb_valid_o out 1; wb_trans_id_o out TRANS_ID_WIDTH; wb_data_o out 64.
REQ-010 The block SHALL have the status ports: rsp_err_o out 1 response to unoccupied slot; count_o out ID_WIDTH+1 occupied slots; empty_o out 1.

Function
REQ-011 Each slot SHALL hold: occupied, killed, trans_id, offset, size, signed.
REQ-012 alloc_ready_o SHALL be 1 iff any slot is unoccupied at the start of the cycle, derived combinationally from state only (no response bypass).
REQ-013 alloc_id_o SHALL be the lowest-index unoccupied slot; it is valid whenever alloc_ready_o=1.
REQ-014 An allocation SHALL occur when alloc_valid_i=1 and alloc_ready_o=1; the slot becomes occupied, not killed, with the metadata captured, next cycle.
REQ-015 alloc_valid_i=1 with alloc_ready_o=0 SHALL be dropped with no state change.
REQ-016 rsp_valid_i=1 to an occupied slot SHALL free that slot next cycle.
REQ-017 A response SHALL produce wb_valid_o=1 exactly one cycle later, with wb_trans_id_o being the slot trans_id, iff the slot was not killed.
REQ-018 wb_data_o SHALL be formed from t = rsp_data_i >> (8*offset), truncated to 8/16/32/64 bits per size, then sign-extended (signed=1) or zero-extended to 64 bits, and registered.
REQ-019 For size 3, offset SHALL be ignored and treated as 0.
REQ-020 Bytes shifted past bit 63 SHALL read as 0 before extension.
REQ-021 wb_trans_id_o and wb_data_o SHALL hold their last values when wb_valid_o=0.
REQ-022 rsp_valid_i=1 to an unoccupied slot SHALL cause no state change, wb_valid_o=0 next cycle, and rsp_err_o=1 for one cycle next cycle.
REQ-023 flush_i=1 SHALL set killed on every slot occupied at the start of the cycle; killed slots stay occupied until their response arrives.
REQ-024 flush_i and an allocation in the same cycle: the new slot SHALL NOT be killed.
REQ-025 flush_i and a response in the same cycle: the response SHALL be suppressed (wb_valid_o=0) and the slot freed.
REQ-026 A response freeing slot k and an allocation in the same cycle SHALL be legal; the allocation uses the pre-cycle free set, so it never receives k that cycle.
REQ-027 count_o SHALL be the number of occupied slots (killed included), registered.
REQ-028 empty_o SHALL be (count_o==0).
REQ-029 count_o SHALL change by +1, -1 or 0 per cycle as alloc/free events dictate.

Reset
REQ-030 With rst_i=1 at a clock edge, all slots SHALL become unoccupied and not killed.
REQ-031 Under reset, the outputs SHALL be: wb_valid_o=0, rsp_err_o=0, wb_data_o=0, wb_trans_id_o=0, count_o=0, empty_o=1; alloc_ready_o=1 and alloc_id_o=0 from the cycle after reset.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight slots.
REQ-033 Responses arriving after reset for pre-reset IDs SHALL be treated as unoccupied (rsp_err_o pulse).

Verification
REQ-034 Fill to full: 8 allocations with trans_id 0..7 -> alloc_id_o 0..7 in order; count_o=8; alloc_ready_o=0; a 9th alloc_valid_i is dropped.
REQ-035 Extraction: slot offset=5, size=1, signed=1, rsp_data_i=64'h00AB_CD00_0000_0000 -> next cycle wb_valid_o=1, wb_data_o=64'hFFFF_FFFF_FFFF_ABCD.
REQ-036 Out-of-order completion: allocate slots 0,1,2; responses in order 2,0,1 -> wb_trans_id_o follows the response order; next allocation gets slot 0 once it is freed.
REQ-037 Flush: 3 slots occupied, flush_i=1 with a simultaneous allocation (slot 3) -> responses to 0..2 give wb_valid_o=0 and free the slots; response to 3 gives wb_valid_o=1.
REQ-038 Full plus free: full buffer, response to slot 4 with alloc_valid_i=1 in the same cycle -> allocation dropped; next cycle alloc_ready_o=1, alloc_id_o=4.
REQ-039 Error and reset: response to an unoccupied slot 6 -> rsp_err_o=1 one cycle, count_o unchanged; rst_i=1 with 5 slots occupied -> count_o=0, empty_o=1.

Source files
------------

// File: rtl/load_id_buffer_if.sv
// Bundle of allocation, response, flush and writeback signals for the
// load ID buffer. The slave modport is the buffer; the master modport is
// the load unit / dcache side that drives it.
interface load_id_buffer_if #(
   parameter int NR_ENTRIES     = 8,
   parameter int ID_WIDTH       = 3,
   parameter int TRANS_ID_WIDTH = 3
) ();
   logic                      alloc_valid_i;
   logic                      alloc_ready_o;
   logic [TRANS_ID_WIDTH-1:0] alloc_trans_id_i;
   logic [2:0]                alloc_offset_i;
   logic [1:0]                alloc_size_i;
   logic                      alloc_signed_i;
   logic [ID_WIDTH-1:0]       alloc_id_o;

   logic                      rsp_valid_i;
   logic [ID_WIDTH-1:0]       rsp_id_i;
   logic [63:0]               rsp_data_i;

   logic                      flush_i;

   logic                      wb_valid_o;
   logic [TRANS_ID_WIDTH-1:0] wb_trans_id_o;
   logic [63:0]               wb_data_o;

   logic                      rsp_err_o;
   logic [ID_WIDTH:0]         count_o;
   logic                      empty_o;

   modport slave (
      input  alloc_valid_i, alloc_trans_id_i, alloc_offset_i, alloc_size_i,
             alloc_signed_i, rsp_valid_i, rsp_id_i, rsp_data_i, flush_i,
      output alloc_ready_o, alloc_id_o, wb_valid_o, wb_trans_id_o, wb_data_o,
             rsp_err_o, count_o, empty_o
   );

   modport master (
      output alloc_valid_i, alloc_trans_id_i, alloc_offset_i, alloc_size_i,
             alloc_signed_i, rsp_valid_i, rsp_id_i, rsp_data_i, flush_i,
      input  alloc_ready_o, alloc_id_o, wb_valid_o, wb_trans_id_o, wb_data_o,
             rsp_err_o, count_o, empty_o
   );
endinterface

// File: rtl/load_id_buffer.sv
// Load ID buffer: hands out dcache request IDs for outstanding loads, keeps
// per-slot load metadata, and turns out-of-order dword responses into
// aligned, extended writeback data. Flushed loads stay resident until their
// response drains them, so an ID is never reused while the dcache owns it.
module load_id_buffer #(
   parameter int NR_ENTRIES     = 8,
   parameter int ID_WIDTH       = 3,
   parameter int TRANS_ID_WIDTH = 3
) (
   input  logic clk_i,
   input  logic rst_i,
   load_id_buffer_if.slave bus
);

   logic [NR_ENTRIES-1:0]     occ_q, kill_q;
   logic [NR_ENTRIES-1:0]     occ_n, kill_n;
   logic [TRANS_ID_WIDTH-1:0] tid_q  [NR_ENTRIES];
   logic [2:0]                off_q  [NR_ENTRIES];
   logic [1:0]                size_q [NR_ENTRIES];
   logic [NR_ENTRIES-1:0]     sgn_q;

   logic                      wb_valid_q, rsp_err_q;
   logic [TRANS_ID_WIDTH-1:0] wb_tid_q;
   logic [63:0]               wb_data_q;
   logic [ID_WIDTH:0]         count_q;

   logic [ID_WIDTH-1:0]       alloc_id;
   logic                      alloc_ready, do_alloc, rsp_hit, rsp_live;
   logic [2:0]                shift_bytes;
   logic [63:0]               shifted, extracted;

   // Lowest-index free slot, from registered state only.
   always_comb begin
      alloc_id = '0;
      for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
         if (!occ_q[i]) alloc_id = ID_WIDTH'(i);
      end
   end

   assign alloc_ready = ~&occ_q;
   assign do_alloc    = bus.alloc_valid_i & alloc_ready;
   assign rsp_hit     = bus.rsp_valid_i & occ_q[bus.rsp_id_i];
   assign rsp_live    = rsp_hit & ~kill_q[bus.rsp_id_i] & ~bus.flush_i;

   // Align the addressed bytes to bit 0, then truncate and extend by size.
   always_comb begin
      shift_bytes = (size_q[bus.rsp_id_i] == 2'd3) ? 3'd0 : off_q[bus.rsp_id_i];
      shifted     = bus.rsp_data_i >> {shift_bytes, 3'b000};
      extracted   = shifted;
      case (size_q[bus.rsp_id_i])
         2'd0: extracted = {{56{sgn_q[bus.rsp_id_i] & shifted[7]}},  shifted[7:0]};
         2'd1: extracted = {{48{sgn_q[bus.rsp_id_i] & shifted[15]}}, shifted[15:0]};
         2'd2: extracted = {{32{sgn_q[bus.rsp_id_i] & shifted[31]}}, shifted[31:0]};
         default: extracted = shifted;
      endcase
   end

   // Next occupancy/kill masks: flush kills pre-cycle residents, a response
   // frees its slot, and the allocation lands on a slot that was free before.
   always_comb begin
      occ_n  = occ_q;
      kill_n = kill_q;
      if (bus.flush_i) kill_n = kill_q | occ_q;
      if (rsp_hit) begin
         occ_n[bus.rsp_id_i]  = 1'b0;
         kill_n[bus.rsp_id_i] = 1'b0;
      end
      if (do_alloc) begin
         occ_n[alloc_id]  = 1'b1;
         kill_n[alloc_id] = 1'b0;
      end
   end

   // Slot state, metadata capture, writeback and status registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         occ_q      <= '0;
         kill_q     <= '0;
         sgn_q      <= '0;
         wb_valid_q <= 1'b0;
         rsp_err_q  <= 1'b0;
         wb_tid_q   <= '0;
         wb_data_q  <= '0;
         count_q    <= '0;
         for (int i = 0; i < NR_ENTRIES; i++) begin
            tid_q[i]  <= '0;
            off_q[i]  <= '0;
            size_q[i] <= '0;
         end
      end else begin
         occ_q      <= occ_n;
         kill_q     <= kill_n;
         wb_valid_q <= rsp_live;
         rsp_err_q  <= bus.rsp_valid_i & ~occ_q[bus.rsp_id_i];
         if (rsp_live) begin
            wb_tid_q  <= tid_q[bus.rsp_id_i];
            wb_data_q <= extracted;
         end
         if (do_alloc) begin
            tid_q[alloc_id]  <= bus.alloc_trans_id_i;
            off_q[alloc_id]  <= bus.alloc_offset_i;
            size_q[alloc_id] <= bus.alloc_size_i;
            sgn_q[alloc_id]  <= bus.alloc_signed_i;
         end
         count_q <= count_q + {{ID_WIDTH{1'b0}}, do_alloc}
                            - {{ID_WIDTH{1'b0}}, rsp_hit};
      end
   end

   assign bus.alloc_ready_o = alloc_ready;
   assign bus.alloc_id_o    = alloc_id;
   assign bus.wb_valid_o    = wb_valid_q;
   assign bus.wb_trans_id_o = wb_tid_q;
   assign bus.wb_data_o     = wb_data_q;
   assign bus.rsp_err_o     = rsp_err_q;
   assign bus.count_o       = count_q;
   assign bus.empty_o       = (count_q == '0);

endmodule
